one_wire_txn_ctrl: RTL and testbench

Transaction sequencer between the 32-entry 1-wire byte buffer and the 1-wire byte link engine.
- On start: issues a bus reset/presence request, then fetches byte_count bytes from the buffer starting at start_addr, and hands each byte to the link transmitter over a valid/ready handshake.
- Reports completion, missing-presence and buffer-timeout conditions to the host control logic.

---
 rtl/one_wire_txn_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_one_wire_txn_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/one_wire_txn_ctrl.sv
// Sequences one 1-wire transaction: bus reset/presence, then buffer reads handed to the link TX.
// Optional trailing Dallas CRC8 byte when OW_CRC8_EN is defined.
module one_wire_txn_ctrl #(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DV_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_start_addr,
    input  logic [5:0]        i_byte_count,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err_presence,
    output logic              o_err_timeout,
    output logic [ADDR_W-1:0] o_buf_rd_addr,
    output logic              o_buf_rd_en,
    input  logic [DATA_W-1:0] i_buf_data,
    input  logic              i_buf_dv,
    output logic              o_ow_rst_req,
    input  logic              i_ow_rst_done,
    input  logic              i_ow_presence,
    output logic              o_ow_tx_valid,
    output logic [DATA_W-1:0] o_ow_tx_data,
    input  logic              i_ow_tx_ready
);

    localparam int unsigned CNT_W = $clog2(DV_TIMEOUT + 1);
    localparam int unsigned REM_W = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUS_RST,
        S_RD_REQ,
        S_RD_WAIT,
        S_TX,
        S_DONE,
        S_ERR
`ifdef OW_CRC8_EN
        , S_CRC_TX
`endif
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [REM_W-1:0]   r_remaining;
    logic [CNT_W-1:0]   r_dv_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_err_presence;
    logic               r_err_timeout;
    logic [ADDR_W-1:0]  r_buf_rd_addr;
    logic               r_buf_rd_en;
    logic               r_ow_rst_req;
    logic               r_ow_tx_valid;
    logic [DATA_W-1:0]  r_ow_tx_data;

`ifdef OW_CRC8_EN
    logic [7:0] r_crc;
    logic [7:0] w_crc_next;

    // Dallas/Maxim CRC8, LSB first, reflected polynomial 0x8C
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] d);
        logic [7:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ 8'h8C;
            else             c = c >> 1;
        end
        return c;
    endfunction

    assign w_crc_next = crc8_step(r_crc, r_ow_tx_data);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_addr         <= '0;
            r_remaining    <= '0;
            r_dv_cnt       <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_err_presence <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_buf_rd_addr  <= '0;
            r_buf_rd_en    <= 1'b0;
            r_ow_rst_req   <= 1'b0;
            r_ow_tx_valid  <= 1'b0;
            r_ow_tx_data   <= '0;
`ifdef OW_CRC8_EN
            r_crc          <= '0;
`endif
        end else begin
            r_done         <= 1'b0;
            r_err_presence <= 1'b0;
            r_err_timeout  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (i_byte_count != 6'd0) begin
                            r_addr       <= i_start_addr;
                            r_remaining  <= i_byte_count;
                            r_busy       <= 1'b1;
                            r_ow_rst_req <= 1'b1;
`ifdef OW_CRC8_EN
                            r_crc        <= '0;
`endif
                            r_state      <= S_BUS_RST;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                S_BUS_RST: begin
                    if (i_ow_rst_done) begin
                        r_ow_rst_req <= 1'b0;
                        if (i_ow_presence) begin
                            r_state <= S_RD_REQ;
                        end else begin
                            r_err_presence <= 1'b1;
                            r_busy         <= 1'b0;
                            r_state        <= S_ERR;
                        end
                    end
                end
                S_RD_REQ: begin
                    r_buf_rd_addr <= r_addr;
                    r_buf_rd_en   <= 1'b1;
                    r_dv_cnt      <= '0;
                    r_state       <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    // Data wins over a timeout landing on the same cycle
                    if (i_buf_dv) begin
                        r_ow_tx_data  <= i_buf_data;
                        r_buf_rd_en   <= 1'b0;
                        r_ow_tx_valid <= 1'b1;
                        r_state       <= S_TX;
                    end else if (r_dv_cnt == CNT_W'(DV_TIMEOUT - 1)) begin
                        r_buf_rd_en   <= 1'b0;
                        r_err_timeout <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= S_ERR;
                    end else begin
                        r_dv_cnt <= r_dv_cnt + CNT_W'(1);
                    end
                end
                S_TX: begin
                    if (i_ow_tx_ready) begin
                        r_ow_tx_valid <= 1'b0;
                        r_addr        <= r_addr + ADDR_W'(1);
                        r_remaining   <= r_remaining - REM_W'(1);
`ifdef OW_CRC8_EN
                        r_crc         <= w_crc_next;
                        if (r_remaining == REM_W'(1)) begin
                            r_ow_tx_valid <= 1'b1;
                            r_ow_tx_data  <= w_crc_next;
                            r_state       <= S_CRC_TX;
                        end else begin
                            r_state <= S_RD_REQ;
                        end
`else
                        if (r_remaining == REM_W'(1)) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_RD_REQ;
                        end
`endif
                    end
                end
`ifdef OW_CRC8_EN
                S_CRC_TX: begin
                    if (i_ow_tx_ready) begin
                        r_ow_tx_valid <= 1'b0;
                        r_done        <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= S_DONE;
                    end
                end
`endif
                S_DONE:  r_state <= S_IDLE;
                S_ERR:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_err_presence = r_err_presence;
    assign o_err_timeout  = r_err_timeout;
    assign o_buf_rd_addr  = r_buf_rd_addr;
    assign o_buf_rd_en    = r_buf_rd_en;
    assign o_ow_rst_req   = r_ow_rst_req;
    assign o_ow_tx_valid  = r_ow_tx_valid;
    assign o_ow_tx_data   = r_ow_tx_data;

endmodule

// File: tb/tb_one_wire_txn_ctrl.sv
// Directed bench for one_wire_txn_ctrl with buffer, bus-reset and link responder models.
module tb_one_wire_txn_ctrl;

    localparam int unsigned ADDR_W     = 5;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned DV_TIMEOUT = 15;
`ifdef OW_CRC8_EN
    localparam int CRC_EN = 1;
`else
    localparam int CRC_EN = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_start;
    logic [ADDR_W-1:0] i_start_addr;
    logic [5:0]        i_byte_count;
    logic              o_busy, o_done, o_err_presence, o_err_timeout;
    logic [ADDR_W-1:0] o_buf_rd_addr;
    logic              o_buf_rd_en;
    logic [DATA_W-1:0] i_buf_data;
    logic              i_buf_dv;
    logic              o_ow_rst_req;
    logic              i_ow_rst_done, i_ow_presence;
    logic              o_ow_tx_valid;
    logic [DATA_W-1:0] o_ow_tx_data;
    logic              i_ow_tx_ready;

    always #5 clk = ~clk;

    one_wire_txn_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DV_TIMEOUT(DV_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_start_addr(i_start_addr),
        .i_byte_count(i_byte_count), .o_busy(o_busy), .o_done(o_done),
        .o_err_presence(o_err_presence), .o_err_timeout(o_err_timeout),
        .o_buf_rd_addr(o_buf_rd_addr), .o_buf_rd_en(o_buf_rd_en), .i_buf_data(i_buf_data),
        .i_buf_dv(i_buf_dv), .o_ow_rst_req(o_ow_rst_req), .i_ow_rst_done(i_ow_rst_done),
        .i_ow_presence(i_ow_presence), .o_ow_tx_valid(o_ow_tx_valid),
        .o_ow_tx_data(o_ow_tx_data), .i_ow_tx_ready(i_ow_tx_ready)
    );

    typedef struct {
        logic [4:0] addr;
        logic [5:0] cnt;
        logic       pres;
        int         lat;
        logic       buf_on;
        int         stall_idx;
        int         stall_len;
        int         exp_done;
        int         exp_errp;
        int         exp_errt;
        int         exp_reads;
        int         exp_bytes;
        int         exp_rst;
    } vec_t;

    vec_t       vecs[7];
    logic [7:0] mem[32];
    logic [7:0] tx_log[$];
    logic [4:0] rd_log[$];

    int n_vec = 0, n_miss = 0;
    int cyc = 0;
    int n_done, n_errp, n_errt, n_reads, n_rst, n_busy_bad, n_unstable;
    int t_rden, t_errt;
    logic model_pres;
    int   model_lat;
    logic model_buf_on;
    int   stall_idx, stall_len, stall_ctr;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        n_done = 0; n_errp = 0; n_errt = 0; n_reads = 0; n_rst = 0;
        n_busy_bad = 0; n_unstable = 0; t_rden = 0; t_errt = 0; stall_ctr = 0;
        tx_log.delete();
        rd_log.delete();
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output monitor: pulse counts, read requests, busy during completion pulses
    initial begin : mon
        logic prev_rden, prev_rst;
        prev_rden = 1'b0;
        prev_rst  = 1'b0;
        forever begin
            @(negedge clk);
            if (o_done) begin n_done++; if (o_busy) n_busy_bad++; end
            if (o_err_presence) begin n_errp++; if (o_busy) n_busy_bad++; end
            if (o_err_timeout) begin
                n_errt++; t_errt = cyc;
                if (o_busy || o_buf_rd_en) n_busy_bad++;
            end
            if (o_buf_rd_en && !prev_rden) begin
                n_reads++; t_rden = cyc; rd_log.push_back(o_buf_rd_addr);
            end
            if (o_ow_rst_req && !prev_rst) n_rst++;
            prev_rden = o_buf_rd_en;
            prev_rst  = o_ow_rst_req;
        end
    end

    // Buffer model: answers a held read request after model_lat cycles
    initial begin : bufm
        int  wcnt;
        logic served;
        wcnt = 0; served = 1'b0;
        forever begin
            @(negedge clk);
            i_buf_dv = 1'b0;
            if (!o_buf_rd_en) begin
                served = 1'b0; wcnt = 0;
            end else if (model_buf_on && !served) begin
                wcnt++;
                if (wcnt >= model_lat) begin
                    i_buf_dv   = 1'b1;
                    i_buf_data = mem[o_buf_rd_addr];
                    served     = 1'b1;
                end
            end
        end
    end

    // Bus reset/presence model: three cycles after the request
    initial begin : rstm
        int  wcnt;
        logic served;
        wcnt = 0; served = 1'b0;
        forever begin
            @(negedge clk);
            i_ow_rst_done = 1'b0;
            if (!o_ow_rst_req) begin
                served = 1'b0; wcnt = 0;
            end else if (!served) begin
                wcnt++;
                if (wcnt >= 3) begin
                    i_ow_rst_done = 1'b1;
                    i_ow_presence = model_pres;
                    served        = 1'b1;
                end
            end
        end
    end

    // Link model: logs accepted bytes, optionally stalls one byte and watches data stability
    initial begin : linkm
        logic       pend;
        logic [7:0] pend_data, held;
        pend = 1'b0; pend_data = '0; held = '0;
        forever begin
            @(negedge clk);
            if (pend) begin tx_log.push_back(pend_data); stall_ctr = 0; end
            if (o_ow_tx_valid && tx_log.size() == stall_idx && stall_ctr < stall_len) begin
                if (stall_ctr == 0) held = o_ow_tx_data;
                else if (o_ow_tx_data != held) n_unstable++;
                stall_ctr++;
                i_ow_tx_ready = 1'b0;
            end else begin
                i_ow_tx_ready = 1'b1;
            end
            pend      = o_ow_tx_valid && i_ow_tx_ready;
            pend_data = o_ow_tx_data;
        end
    end

    function automatic int outs_packed();
        return int'({o_busy, o_done, o_err_presence, o_err_timeout, o_buf_rd_en,
                     o_ow_rst_req, o_ow_tx_valid, o_buf_rd_addr, o_ow_tx_data});
    endfunction

    task automatic wait_end(input string name);
        int k;
        k = 0;
        while ((n_done + n_errp + n_errt) == 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) check({name, "_no_completion"}, 0, 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_start(input logic [4:0] a, input logic [5:0] c);
        i_start = 1'b1; i_start_addr = a; i_byte_count = c;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic run_vec(input int v);
        vec_t       t;
        string      nm;
        logic [4:0] a;
        int         exp_b;
        t  = vecs[v];
        nm = $sformatf("v%0d", v);
        clear_stats();
        model_pres = t.pres; model_lat = t.lat; model_buf_on = t.buf_on;
        stall_idx = t.stall_idx; stall_len = t.stall_len;
        @(negedge clk);
        pulse_start(t.addr, t.cnt);
        wait_end(nm);
        exp_b = t.exp_bytes + ((t.exp_done == 1 && t.cnt != 6'd0) ? CRC_EN : 0);
        check({nm, "_done"},     n_done,  t.exp_done);
        check({nm, "_err_pres"}, n_errp,  t.exp_errp);
        check({nm, "_err_tmo"},  n_errt,  t.exp_errt);
        check({nm, "_reads"},    n_reads, t.exp_reads);
        check({nm, "_bytes"},    int'(tx_log.size()), exp_b);
        check({nm, "_rst_req"},  n_rst,   t.exp_rst);
        check({nm, "_busy_at_pulse"}, n_busy_bad, 0);
        check({nm, "_idle_outs"}, int'({o_busy, o_buf_rd_en, o_ow_rst_req, o_ow_tx_valid}), 0);
        if (t.stall_len > 0) check({nm, "_data_stable"}, n_unstable, 0);
        for (int i = 0; i < t.exp_reads && i < rd_log.size(); i++) begin
            a = t.addr + 5'(i);
            check($sformatf("%s_rd_addr%0d", nm, i), int'(rd_log[i]), int'(a));
        end
        for (int i = 0; i < int'(t.cnt) && i < tx_log.size(); i++) begin
            a = t.addr + 5'(i);
            check($sformatf("%s_tx%0d", nm, i), int'(tx_log[i]), int'(mem[a]));
        end
        if (t.exp_errt == 1) check({nm, "_tmo_latency"}, t_errt - t_rden, DV_TIMEOUT);
`ifdef OW_CRC8_EN
        if (v == 6 && tx_log.size() >= 8) check("v6_crc_byte", int'(tx_log[7]), 'hA2);
`endif
    endtask

    initial begin
        vecs[0] = '{5'd4,  6'd3,  1'b1, 1, 1'b1, -1, 0, 1, 0, 0, 3,  3,  1};
        vecs[1] = '{5'd4,  6'd3,  1'b0, 1, 1'b1, -1, 0, 0, 1, 0, 0,  0,  1};
        vecs[2] = '{5'd4,  6'd2,  1'b1, 1, 1'b0, -1, 0, 0, 0, 1, 1,  0,  1};
        vecs[3] = '{5'd30, 6'd4,  1'b1, 2, 1'b1,  1, 5, 1, 0, 0, 4,  4,  1};
        vecs[4] = '{5'd4,  6'd0,  1'b1, 1, 1'b1, -1, 0, 1, 0, 0, 0,  0,  0};
        vecs[5] = '{5'd0,  6'd32, 1'b1, 3, 1'b1, -1, 0, 1, 0, 0, 32, 32, 1};
        vecs[6] = '{5'd8,  6'd7,  1'b1, 1, 1'b1, -1, 0, 1, 0, 0, 7,  7,  1};

        for (int i = 0; i < 32; i++) mem[i] = 8'hA0 + 8'(i);
        mem[4] = 8'hCC; mem[5] = 8'h44; mem[6] = 8'hBE;
        mem[8] = 8'h02; mem[9] = 8'h1C; mem[10] = 8'hB8; mem[11] = 8'h01;
        mem[12] = 8'h00; mem[13] = 8'h00; mem[14] = 8'h00;

        rst_n = 1'b0; i_start = 1'b0; i_start_addr = '0; i_byte_count = '0;
        i_buf_data = '0; i_buf_dv = 1'b0; i_ow_rst_done = 1'b0; i_ow_presence = 1'b0;
        i_ow_tx_ready = 1'b1;
        model_pres = 1'b1; model_lat = 1; model_buf_on = 1'b1;
        stall_idx = -1; stall_len = 0;
        clear_stats();

        repeat (3) @(negedge clk);
        check("reset_outs_held", outs_packed(), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_outs_released", outs_packed(), 0);

        for (int v = 0; v < 7; v++) run_vec(v);

        // Second start while busy is dropped
        clear_stats();
        model_pres = 1'b1; model_lat = 4; model_buf_on = 1'b1; stall_idx = -1; stall_len = 0;
        pulse_start(5'd4, 6'd2);
        repeat (2) @(negedge clk);
        check("busy_mid_txn", int'(o_busy), 1);
        pulse_start(5'd20, 6'd5);
        wait_end("restart");
        check("restart_done", n_done, 1);
        check("restart_rst_req", n_rst, 1);
        check("restart_bytes", int'(tx_log.size()), 2 + CRC_EN);
        check("restart_reads", n_reads, 2);
        if (rd_log.size() >= 2) begin
            check("restart_addr0", int'(rd_log[0]), 4);
            check("restart_addr1", int'(rd_log[1]), 5);
        end

        // Asynchronous reset while waiting on the buffer
        clear_stats();
        model_buf_on = 1'b0;
        pulse_start(5'd4, 6'd2);
        begin : wait_rd
            int k;
            k = 0;
            while (!o_buf_rd_en && k < 100) begin @(negedge clk); k++; end
            check("abort_rd_en_seen", int'(o_buf_rd_en), 1);
        end
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check("abort_outs_async", outs_packed(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_no_pulse", n_done + n_errp + n_errt, 0);
        check("abort_idle", int'({o_busy, o_buf_rd_en, o_ow_rst_req}), 0);
        model_buf_on = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
